// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//   Multi-cycle unsigned restoring divider. One quotient bit per clock, so a
//   division takes WIDTH RUN cycles plus one DONE cycle. A zero divisor skips
//   the iteration loop and reports quotient = all ones, remainder = dividend.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for start; operands captured when start is seen
//   RUN   | one restoring shift/subtract step per clock, WIDTH steps total
//   DONE  | normal division: done pulse is visible in this state;
//         | zero divisor: result is registered on the edge leaving it
//
// Ports
//   clk          sole clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        request a division (only honoured in IDLE)
//   dividend     unsigned dividend, captured on accepted start
//   divisor      unsigned divisor, captured on accepted start
//   busy         high while in RUN
//   done         one-cycle pulse, quotient/remainder valid
//   quotient     unsigned quotient, held until the next result or reset
//   remainder    unsigned remainder, held until the next result or reset
//   div_by_zero  high with done when the captured divisor was zero
// ---------------------------------------------------------------------------
module restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Partial remainder is one bit wider than the operands: after the shift a
  // remainder just below a large divisor (>= 2^(WIDTH-1)) needs WIDTH+1 bits.
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             last_iter;
  logic             divisor_zero;
  logic             divisor_q_zero;

  // -------------------------------------------------------------------------
  // One restoring step. The subtraction is an add of the ones-complement of
  // the divisor with carry-in 1; the carry out of the WIDTH+1 bit sum is the
  // "no borrow" flag.
  // -------------------------------------------------------------------------
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial     = {1'b0, rem_shift}
              + {1'b0, ~{1'b0, divisor_q}}
              + {{(WIDTH+1){1'b0}}, 1'b1};
    // A set bit shifted out above the trial width would mean the shifted
    // remainder exceeds any divisor, so the trial cannot borrow.
    no_borrow = trial[WIDTH+1] | rem_q[WIDTH];
    rem_step  = no_borrow ? trial[WIDTH:0] : rem_shift;
    quo_step  = {quo_q[WIDTH-2:0], no_borrow};
  end

  assign last_iter      = (cnt_q == LAST_ITER);
  assign divisor_zero   = (divisor == '0);
  assign divisor_q_zero = (divisor_q == '0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and registered result outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            divisor_q   <= divisor;
            rem_q       <= '0;
            quo_q       <= dividend;
            cnt_q       <= '0;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            quotient  <= quo_step;
            remainder <= rem_step[WIDTH-1:0];
            done      <= 1'b1;
          end
        end
        DONE: begin
          // Zero divisor: the quotient register still holds the dividend.
          if (divisor_q_zero) begin
            quotient    <= '1;
            remainder   <= quo_q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend; captured on accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress (RUN state).
REQ-008 SHALL have port done  output  1  one-cycle pulse: quotient/remainder valid.
REQ-009 SHALL have port quotient  output  WIDTH  unsigned quotient.
REQ-010 SHALL have port remainder  output  WIDTH  unsigned remainder.
REQ-011 SHALL have port div_by_zero  output  1  set with done when the captured divisor is 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-013 SHALL, in IDLE with start=1 at edge E0, capture operands, clear partial remainder, load the quotient shift register with dividend, clear the iteration counter, and enter RUN; with start=0 remain in IDLE.
REQ-014 SHALL, in RUN, perform one restoring step per edge: shift {R, Q} left by one; trial = R_shifted - divisor on WIDTH+1 bits; no borrow -> R = trial, Q LSB = 1; borrow -> R unchanged, Q LSB = 0.
REQ-015 SHALL realise the trial subtraction as addition of the ones-complement of divisor with carry-in 1; carry-out 1 means no borrow.
REQ-016 SHALL keep partial remainder WIDTH+1 bits wide so that divisors >= 2^(WIDTH-1) divide correctly.
REQ-017 SHALL execute exactly WIDTH RUN iterations (edges E1..E_WIDTH), then enter DONE.
REQ-018 SHALL drive done=1 for exactly one cycle (the DONE state, after edge E_WIDTH), then return to IDLE at the next edge.
REQ-019 SHALL update quotient/remainder outputs on the edge entering DONE and hold them until the next accepted start or reset.
REQ-020 SHALL, if the captured divisor is 0, skip RUN: E0 -> DONE; at E1 register quotient = all ones, remainder = dividend, div_by_zero=1, done=1 in the following cycle.
REQ-021 SHALL clear div_by_zero on the next accepted start.
REQ-022 SHALL assert busy in RUN only; busy=0 in IDLE and DONE.
REQ-023 SHALL ignore start while in RUN or DONE (no restart, no operand recapture).
REQ-024 SHALL ignore dividend/divisor changes after capture.
REQ-025 SHALL accept a new start in the IDLE cycle immediately following DONE (back-to-back throughput WIDTH+2 cycles).

Reset
REQ-026 SHALL, with rst=1 at a rising edge, enter IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-027 SHALL let rst take priority over start and over any in-flight division; an aborted division produces no done pulse.
REQ-028 SHALL have no asynchronous behaviour; outputs change only at clk rising edges.

Verification
REQ-029 SHALL cover: start with dividend=100, divisor=7 -> busy high 32 cycles, done pulse 33 cycles after start edge, quotient=14, remainder=2, div_by_zero=0.
REQ-030 SHALL cover: 0xFFFFFFFF / 0x80000001 -> quotient=1, remainder=0x7FFFFFFE; and 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-031 SHALL cover: 3 / 10 -> quotient=0, remainder=3; then 5 / 0 -> done 2 cycles after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never high.
REQ-032 SHALL cover: start pulsed again with new operands at cycle 10 of RUN -> ignored; result matches original operands; restart on IDLE cycle after done accepted.
REQ-033 SHALL cover: rst asserted at cycle 16 of RUN -> next cycle busy=0, done=0, all outputs 0; no done pulse follows; subsequent 100/7 correct.
REQ-034 SHALL cover: random operands (>=10000) compared against reference division, including divisor=0 and dividend<divisor cases.
